mpy_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that time-shares one pipelined unsigned multiplier (NA x NB, fixed clock-enable latency LAT) among NREQ requesters, e.g. the I and Q channel mixers.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one product per cycle to the multiplier.
- Tracks the requester ID of each in-flight product in a shadow tag pipeline and returns each result on a single tagged output channel with backpressure.
- The multiplier sits outside this block and is driven through the o_mpy_* / i_mpy_p ports.

---
 rtl/mpy_share_arb.sv | 142 ++++++++++++++
 tb/tb_mpy_share_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpy_share_arb.sv
// Round-robin arbiter/sequencer that time-shares one external pipelined multiplier among NREQ requesters.
// Optional build macro MPY_SHARE_ARB_STATS_EN adds a saturating stall counter output o_stall_cnt.
module mpy_share_arb #(
    parameter int NREQ = 2,
    parameter int NA   = 14,
    parameter int NB   = 16,
    parameter int LAT  = 3,
    parameter int IW   = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*NA-1:0]   i_req_a,
    input  logic [NREQ*NB-1:0]   i_req_b,
    output logic                 o_mpy_ce,
    output logic [NA-1:0]        o_mpy_a,
    output logic [NB-1:0]        o_mpy_b,
    input  logic [NA+NB-1:0]     i_mpy_p,
    output logic                 o_res_valid,
    output logic [IW-1:0]        o_res_id,
    output logic [NA+NB-1:0]     o_res_p,
    input  logic                 i_res_ready
`ifdef MPY_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]          o_stall_cnt
`endif
);

    logic            stall;
    logic [IW-1:0]   ptr;
    logic            gnt_any;
    logic [IW-1:0]   gnt_id;
    logic            tag_vld_p [LAT];
    logic [IW-1:0]   tag_id_p  [LAT];

    // The multiplier and the tag pipeline freeze together whenever a result is refused.
    assign stall    = o_res_valid & ~i_res_ready;
    assign o_mpy_ce = ~stall;

    // Two passes give the wrap-around search: first from ptr upward, then from 0 below ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        if (!stall && !i_reset) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_any && i_req_valid[j] && (IW'(j) >= ptr)) begin
                    gnt_any = 1'b1;
                    gnt_id  = IW'(j);
                end
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!gnt_any && i_req_valid[j] && (IW'(j) < ptr)) begin
                    gnt_any = 1'b1;
                    gnt_id  = IW'(j);
                end
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        o_mpy_a     = '0;
        o_mpy_b     = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (gnt_any && (gnt_id == IW'(j))) begin
                o_req_ready[j] = 1'b1;
                o_mpy_a        = i_req_a[j*NA +: NA];
                o_mpy_b        = i_req_b[j*NB +: NB];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // ---- tag pipeline: stage 0 aligned with the multiplier input register ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < LAT; i++) begin
                tag_vld_p[i] <= 1'b0;
                tag_id_p[i]  <= '0;
            end
        end else if (o_mpy_ce) begin
            tag_vld_p[0] <= gnt_any;
            tag_id_p[0]  <= gnt_any ? gnt_id : '0;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_id_p[i]  <= tag_id_p[i-1];
            end
        end
    end

    // ---- result stage: last tag stage lines up with the multiplier output ----
    assign o_res_valid = tag_vld_p[LAT-1];
    assign o_res_id    = tag_id_p[LAT-1];
    assign o_res_p     = i_mpy_p;

`ifdef MPY_SHARE_ARB_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stall_cnt <= '0;
        end else if (stall && (|i_req_valid)) begin
            o_stall_cnt <= sat_inc16(o_stall_cnt);
        end
    end
`endif

`ifdef FORMAL
    logic [7:0] f_cnt [NREQ];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < NREQ; k++) f_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                f_cnt[k] <= f_cnt[k]
                          + 8'(gnt_any && (gnt_id == IW'(k)))
                          - 8'(o_res_valid && i_res_ready && (o_res_id == IW'(k)));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        a_ready_onehot: assert ($onehot0(o_req_ready));
        if (!i_reset && o_res_valid) begin
            a_res_id_range: assert (o_res_id < IW'(NREQ));
            a_res_matches:  assert (f_cnt[o_res_id] != 8'd0);
        end
    end
`endif

endmodule

// File: tb/tb_mpy_share_arb.sv
// Directed bench for mpy_share_arb with a behavioural clock-enabled multiplier model.
module tb_mpy_share_arb;
    localparam int NREQ = 2;
    localparam int NA   = 14;
    localparam int NB   = 16;
    localparam int LAT  = 3;
    localparam int IW   = 3;
    localparam int PW   = NA + NB;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NA-1:0]   req_a;
    logic [NREQ*NB-1:0]   req_b;
    logic                 mpy_ce;
    logic [NA-1:0]        mpy_a;
    logic [NB-1:0]        mpy_b;
    logic [PW-1:0]        mpy_p;
    logic                 res_valid;
    logic [IW-1:0]        res_id;
    logic [PW-1:0]        res_p;
    logic                 res_ready;
`ifdef MPY_SHARE_ARB_STATS_EN
    logic [15:0]          stall_cnt;
`endif

    int n_tot;
    int n_bad;

    always #5 clk = ~clk;

    mpy_share_arb #(.NREQ(NREQ), .NA(NA), .NB(NB), .LAT(LAT), .IW(IW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_mpy_ce    (mpy_ce),
        .o_mpy_a     (mpy_a),
        .o_mpy_b     (mpy_b),
        .i_mpy_p     (mpy_p),
        .o_res_valid (res_valid),
        .o_res_id    (res_id),
        .o_res_p     (res_p),
        .i_res_ready (res_ready)
`ifdef MPY_SHARE_ARB_STATS_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    // External multiplier: LAT clock-enabled stages, no reset.
    logic [PW-1:0] mp [LAT];
    always_ff @(posedge clk) begin
        if (mpy_ce) begin
            mp[0] <= PW'(mpy_a) * PW'(mpy_b);
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign mpy_p = mp[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int a, input int b);
        req_a[k*NA +: NA] = NA'(a);
        req_b[k*NB +: NB] = NB'(b);
    endtask

    // Call right after the issuing edge; checks the result appears exactly LAT cycles later.
    task automatic wait_res(input string tag, input int id, input longint p);
        for (int k = 1; k <= LAT; k++) begin
            #2;
            if (k < LAT) begin
                chk({tag, "_early"}, res_valid, 0);
            end else begin
                chk({tag, "_valid"}, res_valid, 1);
                chk({tag, "_id"}, res_id, id);
                chk({tag, "_p"}, res_p, p);
            end
            step();
        end
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b1;
        step();

        // Reset: a pending request must not be granted
        set_req(0, 3, 5);
        req_valid = 2'b01;
        #2;
        chk("rst_ready", req_ready, 0);
        chk("rst_ce", mpy_ce, 1);
        chk("rst_mpy_a", mpy_a, 0);
        chk("rst_mpy_b", mpy_b, 0);
        step();
        #2;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        rst = 1'b0;
        req_valid = '0;
        step();

        // Single request
        set_req(0, 3, 5);
        req_valid = 2'b01;
        #2;
        chk("single_ready", req_ready, 2'b01);
        chk("single_mpy_a", mpy_a, 3);
        chk("single_mpy_b", mpy_b, 5);
        step();
        req_valid = '0;
        wait_res("single", 0, 15);

        // Max operands (pointer now 1)
        set_req(1, 16383, 65535);
        req_valid = 2'b10;
        #2;
        chk("max_ready", req_ready, 2'b10);
        step();
        req_valid = '0;
        wait_res("max", 1, 64'd1073659905);

        // Fair rotation, pointer back at 0
        set_req(0, 0, 10);
        set_req(1, 1, 10);
        for (int c = 0; c <= 7 + LAT; c++) begin
            req_valid = (c < 8) ? 2'b11 : 2'b00;
            #2;
            if (c < 8) chk("rot_ready", req_ready, (c % 2 == 1) ? 2'b10 : 2'b01);
            if (c >= LAT) begin
                chk("rot_valid", res_valid, 1);
                chk("rot_id", res_id, (c - LAT) % 2);
                chk("rot_p", res_p, ((c - LAT) % 2) * 10);
            end
            step();
        end
        req_valid = '0;

        // Backpressure: three in flight, then 5 refused cycles with requests pending
        set_req(0, 2, 3);
        req_valid = 2'b01;
        #2;
        chk("bp_g0", req_ready, 2'b01);
        step();
        set_req(1, 4, 5);
        req_valid = 2'b10;
        #2;
        chk("bp_g1", req_ready, 2'b10);
        step();
        set_req(0, 7, 9);
        req_valid = 2'b01;
        #2;
        chk("bp_g2", req_ready, 2'b01);
        step();
        res_ready = 1'b0;
        req_valid = 2'b11;
        set_req(0, 11, 11);
        set_req(1, 12, 12);
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("bp_ce", mpy_ce, 0);
            chk("bp_ready", req_ready, 0);
            chk("bp_hold_valid", res_valid, 1);
            chk("bp_hold_id", res_id, 0);
            chk("bp_hold_p", res_p, 6);
            step();
        end
        // Release with new requests in the same cycle; pointer held at 1
        res_ready = 1'b1;
        set_req(1, 1, 1);
        #2;
        chk("bp_rel_ready", req_ready, 2'b10);
        chk("bp_d0_id", res_id, 0);
        chk("bp_d0_p", res_p, 6);
`ifdef MPY_SHARE_ARB_STATS_EN
        chk("stats_cnt", stall_cnt, 5);
`endif
        step();
        req_valid = '0;
        #2;
        chk("bp_d1_valid", res_valid, 1);
        chk("bp_d1_id", res_id, 1);
        chk("bp_d1_p", res_p, 20);
        step();
        #2;
        chk("bp_d2_valid", res_valid, 1);
        chk("bp_d2_id", res_id, 0);
        chk("bp_d2_p", res_p, 63);
        step();
        #2;
        chk("bp_d3_valid", res_valid, 1);
        chk("bp_d3_id", res_id, 1);
        chk("bp_d3_p", res_p, 1);
        step();
        #2;
        chk("bp_drained", res_valid, 0);

        // Reset mid-flight (pointer now 0): grants 0,1,0 leave pointer at 1
        set_req(0, 2, 2);
        set_req(1, 3, 3);
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("mr_ready", req_ready, (c == 1) ? 2'b10 : 2'b01);
            step();
        end
        req_valid = '0;
        rst = 1'b1;
        #2;
        chk("mr_rst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            #2;
            chk("mr_flushed", res_valid, 0);
            step();
        end
        set_req(0, 6, 7);
        req_valid = 2'b11;
        #2;
        chk("mr_next_grant", req_ready, 2'b01);
        step();
        req_valid = '0;
        wait_res("post_rst", 0, 42);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
